vmem_write_scheduler: RTL
=========================

// Module: vmem_write_scheduler
// PURPOSE
//  Schedules all writes into the 1024x3 video memory (RAM_SINGLE_READ_PORT).
//  Two requesters share its single write port: CPU WVM writes and a hardware fill engine.
//  CPU writes are buffered in a small FIFO, so the non-stalling pipeline never waits.
//  The fill engine clears or paints the whole frame.
//  The block sits between MiniAlu's WVM decode and the VideoMemory write port.
// PARAMETERS
//  ADDR_W   10    video memory address width
//  DATA_W   3     pixel width (R,G,B)
//  LAST     1023  last video memory address written by a fill
//  FIFO_AW  3     log2 of CPU FIFO depth (depth 8)
// PORTS
//  Clock         in   1         system clock, all logic on posedge
//  Reset         in   1         asynchronous, active-high; clears all state
//  iCpuWrite     in   1         CPU WVM strobe, one request per high cycle
//  iCpuAddr      in   ADDR_W    CPU pixel address
//  iCpuData      in   DATA_W    CPU pixel colour
//  iFillStart    in   1         start full-frame fill (level, sampled in IDLE)
//  iFillColor    in   DATA_W    fill colour, latched on accepted start
//  iBlank        in   1         VGA blanking indicator (used only with VMEM_BLANK_ONLY_EN)
//  oVmemWrite    out  1         registered write enable to video memory
//  oVmemAddr     out  ADDR_W    registered write address
//  oVmemData     out  DATA_W    registered write data
//  oFillBusy     out  1         high while FSM in FILL
//  oFillDone     out  1         one-cycle pulse after last fill write
//  oCpuOverflow  out  1         sticky: a CPU write was dropped (FIFO full)
//  oFifoLevel    out  FIFO_AW+1 current CPU FIFO occupancy
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, fill counter 0, colour latch 0.
//  - "Eligible cycle": always, or iBlank=1 when VMEM_BLANK_ONLY_EN is defined.
//  - Push: iCpuWrite=1 with level<8, or with level=8 and a pop in the same cycle, stores {addr,data}.
//    Push with level=8 and no pop drops the entry and sets oCpuOverflow; it stays set until Reset.
//  - Slot arbitration, strict priority, one write per cycle:
//    FIFO non-empty and eligible -> pop head and issue the CPU write.
//    Else FSM=FILL and eligible -> issue {fill counter, colour latch}, counter+1.
//    Else oVmemWrite=0 next cycle. The fill may starve under continuous CPU writes; this is accepted.
//  - Outputs are registered: an issued write appears on oVmem* the cycle after its slot.
//    Latency from iCpuWrite to oVmemWrite is 2 edges when the FIFO is empty and the cycle is eligible.
//  - FIFO order is strict FIFO. Simultaneous push and pop keeps the level unchanged.
//  - FSM transitions:
//    IDLE -> FILL on iFillStart: latch colour, counter=0.
//    FILL -> DONE in the cycle the LAST address is issued.
//    DONE -> IDLE after one cycle, with oFillDone=1 for exactly that cycle.
//  - iFillStart in FILL or DONE is ignored; there is no restart.
//  - The fill counter is ADDR_W bits and never wraps; it stops at LAST.
//  - CPU writes are not ordered against an active fill. The fill may later overwrite a CPU pixel.
//    Software waits for oFillDone before drawing.
//  - Reset mid-fill or with a non-empty FIFO: pending writes are discarded and oVmemWrite drops immediately.
// CONFIGURATION
//  VMEM_BLANK_ONLY_EN defined: writes issue only while iBlank=1, giving tear-free updates.
//    The FIFO absorbs CPU bursts during the active display.
//  Not defined: iBlank is ignored and every cycle is eligible.
// TESTING
//  1. Assert Reset mid-operation -> all outputs 0 asynchronously, oFifoLevel=0, oCpuOverflow=0.
//  2. Macro off: iCpuWrite one cycle, addr 0x155, data 5 -> oVmemWrite=1 for one cycle, 2 edges later,
//     with addr 0x155 and data 5.
//  3. Macro off: iFillStart with colour 3 -> 1024 consecutive writes, addr 0..1023, data 3.
//     oFillBusy high throughout; oFillDone pulses once; then IDLE.
//  4. During a fill at addr 0x010, one CPU write (0x3FF, 6) -> CPU write is inserted.
//     Fill resumes at 0x010 with no skipped or duplicated address.
//  5. Macro on, iBlank=0, 9 back-to-back CPU writes -> oFifoLevel=8, oCpuOverflow=1, 9th dropped.
//     Then iBlank=1 -> 8 writes drain in push order.
//  6. Reset asserted at fill address 0x200 -> oFillBusy=0, no oFillDone.
//     A new iFillStart after release restarts at addr 0.

Source files
------------

// File: rtl/vmem_write_scheduler.sv
// vmem_write_scheduler
// Arbitrates the single write port of the 1024x3 video memory between buffered
// CPU WVM writes (8-entry FIFO, strict priority) and a full-frame fill engine.
// Optional build macro: VMEM_BLANK_ONLY_EN -- when defined, writes are issued
// only while iBlank=1. When it is undefined, every cycle may carry a write.
// Handshake: CPU writes have no back-pressure. A strobe is accepted when the
// FIFO has room, or when it is full and pops in the same cycle. Otherwise the
// write is dropped and oCpuOverflow latches high.
module vmem_write_scheduler #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 3,
   parameter int LAST    = 1023,
   parameter int FIFO_AW = 3
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 iCpuWrite,
   input  logic [ADDR_W-1:0]    iCpuAddr,
   input  logic [DATA_W-1:0]    iCpuData,
   input  logic                 iFillStart,
   input  logic [DATA_W-1:0]    iFillColor,
   input  logic                 iBlank,
   output logic                 oVmemWrite,
   output logic [ADDR_W-1:0]    oVmemAddr,
   output logic [DATA_W-1:0]    oVmemData,
   output logic                 oFillBusy,
   output logic                 oFillDone,
   output logic                 oCpuOverflow,
   output logic [FIFO_AW:0]     oFifoLevel
);

   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int ENTRY_W = ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic [DATA_W-1:0]   color_q, color_d;

   logic [ENTRY_W-1:0]  fifo_mem_q [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]    level_q, level_d;
   logic                ovf_q, ovf_d;

   logic                vmem_write_q, vmem_write_d;
   logic [ADDR_W-1:0]   vmem_addr_q, vmem_addr_d;
   logic [DATA_W-1:0]   vmem_data_q, vmem_data_d;

   logic                eligible;
   logic                fifo_empty, fifo_full;
   logic                pop, push, fill_issue, fill_last;

`ifdef VMEM_BLANK_ONLY_EN
   assign eligible = iBlank;
`else
   logic blank_unused;
   assign blank_unused = iBlank;
   assign eligible     = 1'b1;
`endif

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == (FIFO_AW+1)'(DEPTH));
   // CPU entries always win the slot; the fill only uses slots the FIFO leaves idle.
   assign pop        = !fifo_empty && eligible;
   assign push       = iCpuWrite && (!fifo_full || pop);
   assign fill_issue = !pop && (state_q == ST_FILL) && eligible;
   assign fill_last  = (fill_cnt_q == ADDR_W'(LAST));

   // Next-state logic for the fill FSM, the FIFO bookkeeping and the write slot.
   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      color_d      = color_q;
      vmem_write_d = 1'b0;
      vmem_addr_d  = vmem_addr_q;
      vmem_data_d  = vmem_data_q;
      level_d      = level_q;
      ovf_d        = ovf_q | (iCpuWrite & fifo_full & !pop);

      unique case (state_q)
         ST_IDLE: begin
            if (iFillStart) begin
               state_d    = ST_FILL;
               fill_cnt_d = '0;
               color_d    = iFillColor;
            end
         end
         ST_FILL: begin
            // The counter holds at LAST so it never wraps.
            if (fill_issue) begin
               if (fill_last) state_d = ST_DONE;
               else           fill_cnt_d = fill_cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         vmem_write_d                = 1'b1;
         {vmem_addr_d, vmem_data_d}  = fifo_mem_q[rd_ptr_q];
      end else if (fill_issue) begin
         vmem_write_d = 1'b1;
         vmem_addr_d  = fill_cnt_q;
         vmem_data_d  = color_q;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // State, pointers and the registered write port; reset discards pending work.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         fill_cnt_q   <= '0;
         color_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         ovf_q        <= 1'b0;
         vmem_write_q <= 1'b0;
         vmem_addr_q  <= '0;
         vmem_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         color_q      <= color_d;
         level_q      <= level_d;
         ovf_q        <= ovf_d;
         vmem_write_q <= vmem_write_d;
         vmem_addr_q  <= vmem_addr_d;
         vmem_data_q  <= vmem_data_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents are meaningless outside the occupied window, so no reset.
   always_ff @(posedge Clock) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {iCpuAddr, iCpuData};
   end

   assign oVmemWrite   = vmem_write_q;
   assign oVmemAddr    = vmem_addr_q;
   assign oVmemData    = vmem_data_q;
   assign oFillBusy    = (state_q == ST_FILL);
   assign oFillDone    = (state_q == ST_DONE);
   assign oCpuOverflow = ovf_q;
   assign oFifoLevel   = level_q;

endmodule
